// File: rtl/coo_beat_feeder.sv
// Streams COO nonzeros from a sync-read BRAM into LANES-wide beats for the SpMV multiplier.
// First beat 3 cycles after its last read; the registered beat holds under !out_ready while fetch fills the collect buffer.
module coo_beat_feeder #(
  parameter int LANES    = 4,
  parameter int NUM_ROWS = 128,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [31:0]             nnz,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [3*DATA_W-1:0]     mem_rdata,
  output logic [LANES*DATA_W-1:0] values,
  output logic [LANES*DATA_W-1:0] row_id,
  output logic [LANES*DATA_W-1:0] col_id,
  output logic                    rdy,
  input  logic                    out_ready,
  input  logic                    mult_done,
  output logic                    busy,
  output logic                    done,
  output logic                    err_row
);

  localparam int                CW      = $clog2(LANES + 1) + 1;
  localparam logic [CW-1:0]     LANES_C = CW'(LANES);
  localparam logic [DATA_W-1:0] PAD_ROW = DATA_W'(NUM_ROWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       rem;
  logic              pend;
  logic [CW-1:0]     fill;
  logic [DATA_W-1:0] slot_val [LANES];
  logic [DATA_W-1:0] slot_row [LANES];
  logic [DATA_W-1:0] slot_col [LANES];

  logic          job_start;
  logic          accept;
  logic          last_in_buf;
  logic          xfer;
  logic          issue;
  logic          last_accept;
  logic [CW-1:0] fill_eff;

  logic [DATA_W-1:0] in_val, in_row, in_col;
  logic              bad_row;
  logic [DATA_W-1:0] san_val, san_row, san_col;

  assign in_val  = mem_rdata[2*DATA_W +: DATA_W];
  assign in_row  = mem_rdata[DATA_W   +: DATA_W];
  assign in_col  = mem_rdata[0        +: DATA_W];
  assign bad_row = (in_row >= PAD_ROW);
  assign san_val = bad_row ? '0 : in_val;
  assign san_row = bad_row ? PAD_ROW : in_row;
  assign san_col = bad_row ? '0 : in_col;

  assign mem_rd_en = issue;
  assign mem_addr  = addr;
  assign busy      = (state == S_FETCH) || (state == S_WAIT);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    job_start   = 1'b0;
    accept      = rdy & out_ready;
    last_in_buf = 1'b0;
    xfer        = 1'b0;
    fill_eff    = fill;
    issue       = 1'b0;
    last_accept = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          job_start = 1'b1;
          state_nxt = (nnz == 32'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        last_in_buf = (fill != '0) && (rem == 32'd0) && !pend;
        xfer        = ((fill == LANES_C) || last_in_buf) && (!rdy || accept);
        fill_eff    = xfer ? '0 : fill;
        // The second term pre-issues the first read of the next beat: with the
        // output register empty and nothing moving into it now, the full
        // collect buffer is guaranteed to drain on the cycle that data lands.
        issue       = (rem != 32'd0) &&
                      (((fill_eff + CW'(pend)) < LANES_C) ||
                       ((fill == LANES_C - CW'(1)) && pend && !rdy));
        last_accept = accept && (fill == '0) && !pend && (rem == 32'd0);
        if (last_accept) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mult_done) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch address/count, in-flight flag and the collect buffer.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      addr    <= '0;
      rem     <= '0;
      pend    <= 1'b0;
      fill    <= '0;
      err_row <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        slot_val[k] <= '0;
        slot_row[k] <= PAD_ROW;
        slot_col[k] <= '0;
      end
    end else if (job_start) begin
      addr    <= base_addr;
      rem     <= nnz;
      pend    <= 1'b0;
      fill    <= '0;
      err_row <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        slot_val[k] <= '0;
        slot_row[k] <= PAD_ROW;
        slot_col[k] <= '0;
      end
    end else begin
      pend <= issue;
      if (issue) begin
        addr <= addr + ADDR_W'(1);
        rem  <= rem - 32'd1;
      end
      if (pend && bad_row) begin
        err_row <= 1'b1;
      end
      if (xfer) begin
        // Slots restart as padding so a short final beat is padded for free.
        for (int k = 0; k < LANES; k++) begin
          slot_val[k] <= '0;
          slot_row[k] <= PAD_ROW;
          slot_col[k] <= '0;
        end
        if (pend) begin
          slot_val[0] <= san_val;
          slot_row[0] <= san_row;
          slot_col[0] <= san_col;
        end
        fill <= pend ? CW'(1) : '0;
      end else if (pend) begin
        for (int k = 0; k < LANES; k++) begin
          if (fill == CW'(k)) begin
            slot_val[k] <= san_val;
            slot_row[k] <= san_row;
            slot_col[k] <= san_col;
          end
        end
        fill <= fill + CW'(1);
      end
    end
  end

  // Output register; an empty register always presents an idle beat.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rdy    <= 1'b0;
      values <= '0;
      row_id <= {LANES{PAD_ROW}};
      col_id <= '0;
    end else if (xfer) begin
      rdy <= 1'b1;
      for (int k = 0; k < LANES; k++) begin
        values[k*DATA_W +: DATA_W] <= slot_val[k];
        row_id[k*DATA_W +: DATA_W] <= slot_row[k];
        col_id[k*DATA_W +: DATA_W] <= slot_col[k];
      end
    end else if (accept) begin
      rdy    <= 1'b0;
      values <= '0;
      row_id <= {LANES{PAD_ROW}};
      col_id <= '0;
    end
  end

endmodule

// File: tb/tb_coo_beat_feeder.sv
// Randomised self-checking bench for coo_beat_feeder against a beat-level reference model.
module tb_coo_beat_feeder;
  localparam int L  = 4;
  localparam int NR = 128;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = L * DW;
  localparam logic [BW-1:0] PAD_ROWS = {L{32'd128}};

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   nnz = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [3*DW-1:0] mem_rdata;
  logic [BW-1:0] values, row_id, col_id;
  logic          rdy;
  logic          out_ready = 1'b0;
  logic          mult_done = 1'b0;
  logic          busy, done, err_row;

  logic [3*DW-1:0] mem [0:65535];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  coo_beat_feeder #(.LANES(L), .NUM_ROWS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .base_addr(base_addr), .nnz(nnz),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .values(values), .row_id(row_id), .col_id(col_id), .rdy(rdy),
    .out_ready(out_ready), .mult_done(mult_done), .busy(busy), .done(done),
    .err_row(err_row)
  );

  // Sync-read BRAM; data is junk on any cycle not following a read.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= {$urandom, $urandom, $urandom};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation side
  logic [BW-1:0] obs_v[$], obs_r[$], obs_c[$];
  int            acc_cyc[$], rd_cyc[$];
  logic [AW-1:0] rd_addr[$];
  int            rdy_cnt, stab_err, idle_err, first_rdy;
  logic          prev_stall;
  logic [BW-1:0] pv, pr, pc;

  always @(negedge clk) begin
    if (!rst_l) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_addr.push_back(mem_addr);
        rd_cyc.push_back(cyc);
      end
      if (rdy) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = cyc;
      end
      if (rdy && out_ready) begin
        obs_v.push_back(values);
        obs_r.push_back(row_id);
        obs_c.push_back(col_id);
        acc_cyc.push_back(cyc);
      end
      if (prev_stall && (!rdy || values !== pv || row_id !== pr || col_id !== pc)) stab_err++;
      if (!rdy && (values !== '0 || col_id !== '0 || row_id !== PAD_ROWS)) idle_err++;
      prev_stall = rdy && !out_ready;
      pv = values; pr = row_id; pc = col_id;
    end
  end

  // Reference model: expected beats derived from memory contents
  logic [BW-1:0] exp_v[$], exp_r[$], exp_c[$];
  logic          exp_err;
  logic          done_at1, busy_at1, err_at1, done_pre;

  task automatic clear_mon();
    obs_v.delete(); obs_r.delete(); obs_c.delete();
    acc_cyc.delete(); rd_cyc.delete(); rd_addr.delete();
    rdy_cnt = 0; stab_err = 0; idle_err = 0; first_rdy = -1; prev_stall = 1'b0;
  endtask

  task automatic build_exp(input logic [AW-1:0] base, input int n);
    logic [BW-1:0] v, r, c;
    logic [3*DW-1:0] e;
    logic [AW-1:0] a;
    exp_v.delete(); exp_r.delete(); exp_c.delete();
    exp_err = 1'b0;
    for (int b = 0; b < (n + L - 1) / L; b++) begin
      v = '0; c = '0; r = PAD_ROWS;
      for (int k = 0; k < L; k++) begin
        if (b * L + k < n) begin
          a = base + AW'(b * L + k);
          e = mem[a];
          if (e[63:32] < 32'(NR)) begin
            v[k*DW +: DW] = e[95:64];
            r[k*DW +: DW] = e[63:32];
            c[k*DW +: DW] = e[31:0];
          end else begin
            exp_err = 1'b1;
          end
        end
      end
      exp_v.push_back(v); exp_r.push_back(r); exp_c.push_back(c);
    end
  endtask

  task automatic load(input logic [AW-1:0] base, input int n, input int kind);
    logic [AW-1:0] a;
    int r;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      if (kind == 0) begin
        mem[a] = {32'(i + 1), 32'(i + 1), 32'(i + 1)};
      end else begin
        r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(128, 400)) : int'($urandom_range(0, 127));
        mem[a] = {32'($urandom), 32'(r), 32'($urandom_range(0, 255))};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int beat_mismatches();
    int m = 0;
    if (obs_v.size() != exp_v.size()) m++;
    for (int b = 0; b < obs_v.size() && b < exp_v.size(); b++)
      if (obs_v[b] !== exp_v[b] || obs_r[b] !== exp_r[b] || obs_c[b] !== exp_c[b]) m++;
    return m;
  endfunction

  function automatic int addr_mismatches(input logic [AW-1:0] base, input int n);
    int m = 0;
    logic [AW-1:0] ea;
    if (rd_addr.size() != n) m++;
    for (int i = 0; i < rd_addr.size() && i < n; i++) begin
      ea = base + AW'(i);
      if (rd_addr[i] !== ea) m++;
    end
    return m;
  endfunction

  // mode 0: out_ready=1; mode 1: random out_ready; mode 2: 5-cycle stall on beat 0
  task automatic run_job(input logic [AW-1:0] base, input int n, input int mode, output bit tmo);
    int c;
    int stall_left;
    clear_mon();
    build_exp(base, n);
    tmo = 0;
    base_addr = base; nnz = n; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    done_at1 = done; busy_at1 = busy; err_at1 = err_row;
    stall_left = 5;
    c = 0;
    while (obs_v.size() < exp_v.size() && c < 3000) begin
      if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2) begin
        if (rdy && stall_left > 0) begin out_ready = 1'b0; stall_left--; end
        else out_ready = 1'b1;
      end
      tick();
      c++;
    end
    if (c >= 3000) tmo = 1;
    out_ready = 1'b1;
    tick(); tick();
    done_pre = done;
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    c = 0;
    while (!done && c < 20) begin tick(); c++; end
    if (!done) tmo = 1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (3) tick();
    n_chk++; if (rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b want=0", rdy); end
    n_chk++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b want=0", mem_rd_en); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_chk++; if (err_row !== 1'b0) begin n_err++; $display("FAIL reset_err_row got=%b want=0", err_row); end
    n_chk++; if (values !== '0) begin n_err++; $display("FAIL reset_values got=%h want=0", values); end
    n_chk++; if (col_id !== '0) begin n_err++; $display("FAIL reset_col got=%h want=0", col_id); end
    n_chk++; if (row_id !== PAD_ROWS) begin n_err++; $display("FAIL reset_row got=%h want=%h", row_id, PAD_ROWS); end
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    bit tmo;
    load(16'h0010, 4, 0);
    run_job(16'h0010, 4, 0, tmo);
    n_chk++; if (tmo) begin n_err++; $display("FAIL single_timeout got=1 want=0"); end
    n_chk++; if (obs_v.size() != 1) begin n_err++; $display("FAIL single_beats got=%0d want=1", obs_v.size()); end
    n_chk++; if (rdy_cnt != 1) begin n_err++; $display("FAIL single_rdy_cycles got=%0d want=1", rdy_cnt); end
    if (obs_v.size() == 1) begin
      n_chk++; if (obs_v[0] !== {32'd4, 32'd3, 32'd2, 32'd1}) begin n_err++; $display("FAIL single_values got=%h want=4,3,2,1", obs_v[0]); end
      n_chk++; if (obs_r[0] !== {32'd4, 32'd3, 32'd2, 32'd1}) begin n_err++; $display("FAIL single_rows got=%h want=4,3,2,1", obs_r[0]); end
    end
    if (rd_cyc.size() == 4) begin
      n_chk++; if (first_rdy - rd_cyc[3] != 3) begin n_err++; $display("FAIL single_latency got=%0d want=3", first_rdy - rd_cyc[3]); end
    end
    n_chk++; if (done_pre !== 1'b0) begin n_err++; $display("FAIL single_done_early got=%b want=0", done_pre); end
    n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL single_done got=%b/%b want=1/0", done, busy); end
  endtask

  task automatic test_partial_beat();
    bit tmo;
    load(16'h0100, 6, 0);
    run_job(16'h0100, 6, 0, tmo);
    n_chk++; if (tmo) begin n_err++; $display("FAIL partial_timeout got=1 want=0"); end
    n_chk++; if (beat_mismatches() != 0) begin n_err++; $display("FAIL partial_beats bad=%0d want=0", beat_mismatches()); end
    n_chk++; if (rdy_cnt != 2) begin n_err++; $display("FAIL partial_rdy_cycles got=%0d want=2", rdy_cnt); end
    if (obs_v.size() == 2) begin
      n_chk++; if (obs_v[1] !== {32'd0, 32'd0, 32'd6, 32'd5}) begin n_err++; $display("FAIL partial_values got=%h want=0,0,6,5", obs_v[1]); end
      n_chk++; if (obs_r[1][BW-1:2*DW] !== {32'd128, 32'd128}) begin n_err++; $display("FAIL partial_pad_rows got=%h want=128,128", obs_r[1][BW-1:2*DW]); end
    end
  endtask

  task automatic test_stall();
    bit tmo;
    int early;
    load(16'h0200, 12, 1);
    run_job(16'h0200, 12, 2, tmo);
    n_chk++; if (tmo) begin n_err++; $display("FAIL stall_timeout got=1 want=0"); end
    n_chk++; if (stab_err != 0) begin n_err++; $display("FAIL stall_hold unstable=%0d want=0", stab_err); end
    n_chk++; if (beat_mismatches() != 0) begin n_err++; $display("FAIL stall_beats bad=%0d want=0", beat_mismatches()); end
    n_chk++; if (rdy_cnt != 8) begin n_err++; $display("FAIL stall_rdy_cycles got=%0d want=8", rdy_cnt); end
    n_chk++; if (addr_mismatches(16'h0200, 12) != 0) begin n_err++; $display("FAIL stall_addrs bad=%0d want=0", addr_mismatches(16'h0200, 12)); end
    if (acc_cyc.size() == 3) begin
      n_chk++; if (acc_cyc[1] - acc_cyc[0] != 1) begin n_err++; $display("FAIL stall_beat1_gap got=%0d want=1", acc_cyc[1] - acc_cyc[0]); end
      early = 0;
      foreach (rd_cyc[i]) if (rd_cyc[i] < acc_cyc[0]) early++;
      n_chk++; if (early != 2 * L) begin n_err++; $display("FAIL stall_reads_held got=%0d want=%0d", early, 2 * L); end
    end
  endtask

  task automatic test_nnz_zero();
    bit tmo;
    run_job(16'h0300, 0, 0, tmo);
    n_chk++; if (tmo) begin n_err++; $display("FAIL zero_timeout got=1 want=0"); end
    n_chk++; if (done_at1 !== 1'b1 || busy_at1 !== 1'b0) begin n_err++; $display("FAIL zero_done_1cyc got=%b/%b want=1/0", done_at1, busy_at1); end
    n_chk++; if (rdy_cnt != 0) begin n_err++; $display("FAIL zero_rdy got=%0d want=0", rdy_cnt); end
    n_chk++; if (rd_addr.size() != 0) begin n_err++; $display("FAIL zero_reads got=%0d want=0", rd_addr.size()); end
  endtask

  task automatic test_bad_row();
    bit tmo;
    load(16'h0400, 5, 0);
    mem[16'h0402][63:32] = 32'd200;
    run_job(16'h0400, 5, 0, tmo);
    n_chk++; if (tmo) begin n_err++; $display("FAIL badrow_timeout got=1 want=0"); end
    n_chk++; if (beat_mismatches() != 0) begin n_err++; $display("FAIL badrow_beats bad=%0d want=0", beat_mismatches()); end
    if (obs_v.size() == 2) begin
      n_chk++; if (obs_v[0][2*DW +: DW] !== 32'd0 || obs_r[0][2*DW +: DW] !== 32'd128) begin
        n_err++; $display("FAIL badrow_lane got=%0d/%0d want=0/128", obs_v[0][2*DW +: DW], obs_r[0][2*DW +: DW]); end
    end
    n_chk++; if (err_row !== 1'b1) begin n_err++; $display("FAIL badrow_sticky got=%b want=1", err_row); end
    load(16'h0500, 4, 0);
    run_job(16'h0500, 4, 0, tmo);
    n_chk++; if (err_at1 !== 1'b0 || err_row !== 1'b0) begin n_err++; $display("FAIL badrow_clear got=%b/%b want=0/0", err_at1, err_row); end
  endtask

  task automatic test_wrap();
    bit tmo;
    logic [AW-1:0] wexp [4];
    wexp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    load(16'hFFFE, 4, 0);
    run_job(16'hFFFE, 4, 0, tmo);
    n_chk++; if (rd_addr.size() != 4) begin n_err++; $display("FAIL wrap_reads got=%0d want=4", rd_addr.size()); end
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
      n_chk++; if (rd_addr[i] !== wexp[i]) begin n_err++; $display("FAIL wrap_addr%0d got=%h want=%h", i, rd_addr[i], wexp[i]); end
    end
    n_chk++; if (beat_mismatches() != 0) begin n_err++; $display("FAIL wrap_beats bad=%0d want=0", beat_mismatches()); end
  endtask

  task automatic test_reset_mid_job();
    bit tmo;
    int c;
    load(16'h0600, 8, 1);
    clear_mon();
    base_addr = 16'h0600; nnz = 8; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!(obs_v.size() >= 1 && rdy) && c < 200) begin
      if (obs_v.size() >= 1) out_ready = 1'b0;
      tick(); c++;
    end
    n_chk++; if (c >= 200) begin n_err++; $display("FAIL rstmid_beat1_timeout got=%0d want<200", c); end
    #2 rst_l = 1'b0;
    #1;
    n_chk++; if (rdy !== 1'b0 || mem_rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rstmid_ctrl got=%b%b%b%b want=0000", rdy, mem_rd_en, busy, done); end
    n_chk++; if (values !== '0 || col_id !== '0 || row_id !== PAD_ROWS) begin
      n_err++; $display("FAIL rstmid_beat got=%h/%h want=0/%h", values, row_id, PAD_ROWS); end
    tick();
    rst_l = 1'b1;
    out_ready = 1'b1;
    clear_mon();
    repeat (4) tick();
    n_chk++; if (rdy_cnt != 0 || rd_addr.size() != 0) begin n_err++; $display("FAIL rstmid_quiet got=%0d/%0d want=0/0", rdy_cnt, rd_addr.size()); end
    load(16'h0700, 4, 0);
    run_job(16'h0700, 4, 0, tmo);
    n_chk++; if (tmo || beat_mismatches() != 0 || rdy_cnt != 1) begin
      n_err++; $display("FAIL rstmid_clean tmo=%0d bad=%0d rdy=%0d want=0/0/1", tmo, beat_mismatches(), rdy_cnt); end
  endtask

  task automatic test_random_jobs();
    bit tmo;
    logic [AW-1:0] b;
    int n;
    for (int j = 0; j < 30; j++) begin
      b = AW'($urandom);
      n = $urandom_range(0, 17);
      load(b, n, 1);
      run_job(b, n, 1, tmo);
      n_chk++; if (tmo) begin n_err++; $display("FAIL rand%0d_timeout got=1 want=0", j); end
      n_chk++; if (beat_mismatches() != 0) begin n_err++; $display("FAIL rand%0d_beats bad=%0d want=0 nnz=%0d", j, beat_mismatches(), n); end
      n_chk++; if (addr_mismatches(b, n) != 0) begin n_err++; $display("FAIL rand%0d_addrs bad=%0d want=0", j, addr_mismatches(b, n)); end
      n_chk++; if (err_row !== exp_err) begin n_err++; $display("FAIL rand%0d_err_row got=%b want=%b", j, err_row, exp_err); end
      n_chk++; if (stab_err != 0 || idle_err != 0) begin n_err++; $display("FAIL rand%0d_hold unstable=%0d idle=%0d want=0/0", j, stab_err, idle_err); end
      n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rand%0d_done got=%b/%b want=1/0", j, done, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_partial_beat();
    test_stall();
    test_nnz_zero();
    test_bad_row();
    test_wrap();
    test_reset_mid_job();
    test_random_jobs();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog sim_time exceeded");
    $fatal(1, "watchdog");
  end

endmodule
